cpa_resolver: RTL and testbench

//   Sequential carry-propagate resolver for the multiplier back end. Accepts the

---
 rtl/mul_pkg.sv | 20 ++
 rtl/cpa_resolver_if.sv | 28 ++
 rtl/cpa_chunk_adder.sv | 15 +
 rtl/cpa_resolver.sv | 125 ++++++++++++
 tb/tb_cpa_resolver.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared multiplier back-end constants and types.
package mul_pkg;

    localparam int MUL_WIDTH = 65;
    localparam int XLEN      = 32;
    localparam int CPA_CHUNK = 16;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int NCHUNK = ceil_div(MUL_WIDTH, CPA_CHUNK);

    typedef enum logic [1:0] {
        CPA_IDLE,
        CPA_ADD,
        CPA_DONE
    } cpa_state_t;

endpackage

// File: rtl/cpa_resolver_if.sv
// Operand/result handshake bundle between CSA tree, resolver and PE writeback.
interface cpa_resolver_if #(
    parameter int WIDTH = mul_pkg::MUL_WIDTH,
    parameter int XLEN  = mul_pkg::XLEN
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             in_hi_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [XLEN-1:0]  out_word;
    logic             busy;

    // Producer/consumer side (CSA tree upstream, writeback downstream).
    modport master (
        output in_valid, in_sum, in_carry, in_hi_sel, out_ready,
        input  in_ready, out_valid, out_result, out_word, busy
    );

    // Resolver side.
    modport slave (
        input  in_valid, in_sum, in_carry, in_hi_sel, out_ready,
        output in_ready, out_valid, out_result, out_word, busy
    );
endinterface

// File: rtl/cpa_chunk_adder.sv
// CHUNK-bit ripple slice of the carry-propagate adder; purely combinational.
module cpa_chunk_adder #(
    parameter int CHUNK = mul_pkg::CPA_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    // One wide add produces both the slice sum and its carry out.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end
endmodule

// File: rtl/cpa_resolver.sv
// Sequential carry-propagate resolver: adds the CSA sum/carry pair CHUNK bits
// per cycle and returns the full product plus the selected XLEN-bit half.
module cpa_resolver #(
    parameter int WIDTH = mul_pkg::MUL_WIDTH,
    parameter int CHUNK = mul_pkg::CPA_CHUNK,
    parameter int XLEN  = mul_pkg::XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    cpa_resolver_if.slave bus
);
    import mul_pkg::*;

    localparam int NUM_CHUNK = ceil_div(WIDTH, CHUNK);
    localparam int PW        = NUM_CHUNK * CHUNK;
    localparam int IDXW      = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;

    cpa_state_t                          state_q, state_d;
    logic [NUM_CHUNK-1:0][CHUNK-1:0]     op_a_q, op_a_d;
    logic [NUM_CHUNK-1:0][CHUNK-1:0]     op_b_q, op_b_d;
    logic [PW-1:0]                       result_q, result_d;
    logic [IDXW-1:0]                     idx_q, idx_d;
    logic                                cin_q, cin_d;
    logic                                hi_sel_q, hi_sel_d;
    logic                                out_valid_q, out_valid_d;
    logic [XLEN-1:0]                     out_word_q, out_word_d;

    logic [CHUNK-1:0]                    chunk_sum;
    logic                                chunk_cout;
    logic [31:0]                         shamt;

    // Single shared slice adder, steered by the chunk index.
    cpa_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (op_a_q[idx_q]),
        .b    (op_b_q[idx_q]),
        .cin  (cin_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Next-state, operand capture and per-chunk result merge.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        cin_d       = cin_q;
        hi_sel_d    = hi_sel_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        // Result is kept flat; the active slice is merged with a shifted mask
        // rather than a variable part-select.
        shamt       = 32'(idx_q) * 32'(CHUNK);

        unique case (state_q)
            CPA_IDLE: begin
                if (bus.in_valid) begin
                    op_a_d   = PW'(bus.in_sum);
                    op_b_d   = PW'(bus.in_carry);
                    hi_sel_d = bus.in_hi_sel;
                    idx_d    = '0;
                    cin_d    = 1'b0;
                    state_d  = CPA_ADD;
                end
            end
            CPA_ADD: begin
                result_d = (result_q & ~(PW'({CHUNK{1'b1}}) << shamt))
                         | (PW'(chunk_sum) << shamt);
                cin_d    = chunk_cout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == IDXW'(NUM_CHUNK - 1)) begin
                    state_d     = CPA_DONE;
                    out_valid_d = 1'b1;
                    out_word_d  = hi_sel_q ? result_d[2*XLEN-1:XLEN] : result_d[XLEN-1:0];
                end
            end
            CPA_DONE: begin
                if (bus.out_ready) begin
                    state_d     = CPA_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = CPA_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CPA_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            cin_q       <= 1'b0;
            hi_sel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            cin_q       <= cin_d;
            hi_sel_q    <= hi_sel_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    // Status and result outputs; padding bits above WIDTH never leave the block.
    always_comb begin
        bus.in_ready   = (state_q == CPA_IDLE);
        bus.busy       = (state_q != CPA_IDLE);
        bus.out_valid  = out_valid_q;
        bus.out_result = result_q[WIDTH-1:0];
        bus.out_word   = out_word_q;
    end

endmodule

// File: tb/tb_cpa_resolver.sv
// Self-checking bench for cpa_resolver: directed cases with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cpa_resolver;

    localparam int W   = 65;
    localparam int XL  = 32;
    localparam int NCH = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cpa_resolver_if #(.WIDTH(W), .XLEN(XL)) bus ();

    cpa_resolver #(.WIDTH(W), .CHUNK(16), .XLEN(XL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XL-1:0] pick_word(input logic [W-1:0] r, input logic hi);
        return hi ? r[2*XL-1:XL] : r[XL-1:0];
    endfunction

    // Behavioural model: one outstanding op; result appears NCH edges after
    // acceptance and stays until the downstream handshake.
    logic          m_busy;
    int            m_cnt;
    logic [W-1:0]  m_pend;
    logic          m_pend_hi;
    logic [W-1:0]  m_last;
    logic [XL-1:0] m_last_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            m_pend      <= '0;
            m_pend_hi   <= 1'b0;
            m_last      <= '0;
            m_last_word <= '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy    <= 1'b1;
                m_cnt     <= 0;
                m_pend    <= bus.in_sum + bus.in_carry;
                m_pend_hi <= bus.in_hi_sel;
            end
        end else if (m_cnt < NCH) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == NCH - 1) begin
                m_last      <= m_pend;
                m_last_word <= pick_word(m_pend, m_pend_hi);
            end
        end else if (bus.out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("out_valid", W'(bus.out_valid), W'(m_busy && (m_cnt == NCH)));
        check("in_ready",  W'(bus.in_ready),  W'(!m_busy));
        check("busy",      W'(bus.busy),      W'(m_busy));
        if (!m_busy || (m_cnt == NCH)) begin
            check("out_result", bus.out_result, m_last);
            check("out_word",   W'(bus.out_word), W'(m_last_word));
        end
    end

    // Issue one op at a negedge, measure latency, check literal results,
    // optionally stall in DONE while poking in_valid, then complete.
    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] c, input logic hi,
                          input logic [W-1:0] er, input logic [XL-1:0] ew,
                          input int hold, input string tag);
        int lat;
        int waits;
        waits = 0;
        while (!bus.in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check({tag, "_in_ready"}, W'(bus.in_ready), W'(1'b1));
        bus.in_sum    = s;
        bus.in_carry  = c;
        bus.in_hi_sel = hi;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_sum    = ~s;
        bus.in_carry  = W'($urandom);
        bus.in_hi_sel = ~hi;
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(NCH));
        check({tag, "_result"},  bus.out_result, er);
        check({tag, "_word"},    W'(bus.out_word), W'(ew));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_sum   = W'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"},  W'(bus.out_valid), W'(1'b1));
            check({tag, "_hold_result"}, bus.out_result, er);
            check({tag, "_hold_ready"},  W'(bus.in_ready), W'(1'b0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    logic [W-1:0] all_ones;

    initial begin
        all_ones      = '1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.in_hi_sel = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid",  W'(bus.out_valid), W'(1'b0));
        check("rst_in_ready",   W'(bus.in_ready),  W'(1'b1));
        check("rst_busy",       W'(bus.busy),      W'(1'b0));
        check("rst_out_result", bus.out_result,    W'(0));
        check("rst_out_word",   W'(bus.out_word),  W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op(W'(5), W'(3), 1'b0, W'(8), 32'h8, 0, "t1");
        run_op(65'h0_FFFF_FFFF_FFFF_FFFF, W'(1), 1'b1,
               65'h1_0000_0000_0000_0000, 32'h0, 0, "t2");
        run_op(all_ones, W'(1), 1'b0, W'(0), 32'h0, 0, "t3");
        run_op(-W'(6), W'(2), 1'b0, 65'h1_FFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 0, "t4lo");
        run_op(-W'(6), W'(2), 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 0, "t4hi");
        run_op(W'(100), W'(23), 1'b0, W'(123), 32'd123, 10, "t5");
        run_op(W'(1), W'(1), 1'b0, W'(2), 32'd2, 0, "t5next");

        // Abort mid-ADD (idx==2) with an asynchronous reset.
        bus.in_sum   = W'(123);
        bus.in_carry = W'(456);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", W'(bus.out_valid), W'(1'b0));
        check("t6_rst_ready", W'(bus.in_ready),  W'(1'b1));
        check("t6_rst_busy",  W'(bus.busy),      W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(W'(7), W'(9), 1'b0, W'(16), 32'd16, 0, "t6");

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 800; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_sum    = W'({$urandom, $urandom, $urandom});
            bus.in_carry  = W'({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 7) == 0) bus.in_sum = all_ones;
            if ($urandom_range(0, 7) == 0) bus.in_carry = W'(1);
            bus.in_hi_sel = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
